// File: rtl/disp_src_sel.sv
// Registered N-channel display source selector with a switch settle filter,
// an auto-rotate mode and a fixed blanking interval on every channel change.
module disp_src_sel #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    NUM_CH        = 3,
  parameter int                    SEL_WIDTH     = 4,
  parameter int                    SETTLE_CYCLES = 1_000_000,
  parameter int                    BLANK_CYCLES  = 16,
  parameter int                    DWELL_CYCLES  = 100_000_000,
  parameter logic [DATA_WIDTH-1:0] BLANK_VALUE   = {DATA_WIDTH{1'b0}}
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [SEL_WIDTH-1:0]                          sw_mode,
  input  logic                                          auto_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                  din,
  output logic [DATA_WIDTH-1:0]                         y,
  output logic                                          y_valid,
  output logic [((NUM_CH > 2) ? $clog2(NUM_CH) : 1)-1:0] cur_ch,
  output logic                                          switching
);

  localparam int CH_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int BLANK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int DWELL_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [CH_W-1:0]     LAST_CH     = CH_W'(NUM_CH - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [BLANK_W-1:0]  BLANK_LAST  = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SHOW   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]      cand_q, cand_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [BLANK_W-1:0]   blank_q, blank_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DATA_WIDTH-1:0] y_d;
  logic                 y_valid_d;

  logic [SEL_WIDTH-3:0] req_raw;
  logic [CH_W-1:0]      req;
  logic [CH_W-1:0]      next_ch;
  logic                 sw_unused;

  assign req_raw   = sw_mode[SEL_WIDTH-1:2];
  assign sw_unused = ^sw_mode[1:0];

  // Out-of-range channel requests fold onto channel 0.
  always_comb begin
    req = '0;
    if (int'(req_raw) < NUM_CH) req = CH_W'(req_raw);
  end

  assign next_ch = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;

  // State register
  // NOTE: sequential state uses non-blocking assignments and resets
  // asynchronously, so every flop is defined the instant reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_SHOW;
    else       state_q <= state_d;
  end

  // Next-state and counter update. Counters stop at their terminal value
  // because the state always leaves before they could step past it.
  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    cand_d   = cand_q;
    settle_d = settle_q;
    blank_d  = '0;
    dwell_d  = '0;
    case (state_q)
      ST_SHOW: begin
        if (auto_en) begin
          if (dwell_q == DWELL_LAST) begin
            cur_ch_d = next_ch;
            state_d  = ST_BLANK;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end else if (req != cur_ch_q) begin
          cand_d   = req;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (auto_en || (req == cur_ch_q)) begin
          state_d = ST_SHOW;
        end else if (req != cand_q) begin
          cand_d   = req;
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          cur_ch_d = cand_q;
          state_d  = ST_BLANK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_BLANK: begin
        if (blank_q == BLANK_LAST) state_d = ST_SHOW;
        else                       blank_d = blank_q + 1'b1;
      end
      default: state_d = ST_SHOW;
    endcase
  end

  // Output word follows the state being entered, so y and y_valid line up
  // with the state register and blanking covers exactly BLANK_CYCLES cycles.
  always_comb begin
    y_d       = din[cur_ch_q*DATA_WIDTH +: DATA_WIDTH];
    y_valid_d = 1'b1;
    if (state_d == ST_BLANK) begin
      y_d       = BLANK_VALUE;
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_ch_q <= '0;
      cand_q   <= '0;
      settle_q <= '0;
      blank_q  <= '0;
      dwell_q  <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
    end else begin
      cur_ch_q <= cur_ch_d;
      cand_q   <= cand_d;
      settle_q <= settle_d;
      blank_q  <= blank_d;
      dwell_q  <= dwell_d;
      y        <= y_d;
      y_valid  <= y_valid_d;
    end
  end

  assign cur_ch    = cur_ch_q;
  assign switching = (state_q != ST_SHOW);

endmodule

// File: tb/tb_disp_src_sel.sv
// Scoreboard bench for disp_src_sel: the driver pushes expected outputs from a
// behavioural model, a monitor pops and compares them after every clock edge.
module tb_disp_src_sel;

  localparam int DW     = 8;
  localparam int NCH    = 3;
  localparam int SETTLE = 3;
  localparam int BLANK  = 2;
  localparam int DWELL  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sw_mode = 4'b0000;
  logic        auto_en = 1'b0;
  logic [23:0] din = 24'h332211;
  logic [7:0]  y;
  logic        y_valid;
  logic [1:0]  cur_ch;
  logic        switching;

  disp_src_sel #(
    .DATA_WIDTH   (DW),
    .NUM_CH       (NCH),
    .SEL_WIDTH    (4),
    .SETTLE_CYCLES(SETTLE),
    .BLANK_CYCLES (BLANK),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_mode  (sw_mode),
    .auto_en  (auto_en),
    .din      (din),
    .y        (y),
    .y_valid  (y_valid),
    .cur_ch   (cur_ch),
    .switching(switching)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic       v;
    logic [1:0] ch;
    logic       sw;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: channel shown, how long a new request has been held,
  // how many blank cycles remain, how many cycles auto mode has shown.
  int m_cur, m_cand, m_held, m_blank, m_dwell;
  bit m_pend;

  function automatic void model_reset();
    m_cur = 0; m_cand = 0; m_held = 0; m_blank = 0; m_dwell = 0; m_pend = 0;
  endfunction

  function automatic exp_t model_step(input logic [3:0] s, input logic a, input logic [23:0] d);
    exp_t r;
    int req;
    req = int'(s[3:2]);
    if (req >= NCH) req = 0;
    if (m_blank > 0) begin
      m_blank--;
    end else if (a) begin
      if (m_pend) begin
        m_pend  = 0;
        m_dwell = 0;
      end else begin
        m_dwell++;
        if (m_dwell == DWELL) begin
          m_cur   = (m_cur + 1) % NCH;
          m_dwell = 0;
          m_blank = BLANK;
        end
      end
    end else begin
      m_dwell = 0;
      if (!m_pend) begin
        if (req != m_cur) begin
          m_pend = 1; m_cand = req; m_held = 0;
        end
      end else if (req == m_cur) begin
        m_pend = 0;
      end else if (req != m_cand) begin
        m_cand = req; m_held = 0;
      end else begin
        m_held++;
        if (m_held == SETTLE) begin
          m_cur   = m_cand;
          m_pend  = 0;
          m_blank = BLANK;
        end
      end
    end
    r.y  = (m_blank > 0) ? 8'h00 : d[m_cur*8 +: 8];
    r.v  = (m_blank == 0);
    r.ch = 2'(m_cur);
    r.sw = m_pend || (m_blank > 0);
    return r;
  endfunction

  task automatic apply(input logic [3:0] s, input logic a);
    sw_mode = s;
    auto_en = a;
    exp_q.push_back(model_step(s, a, din));
  endtask

  task automatic tick(input logic [3:0] s, input logic a, input bit rnd_din = 1'b0);
    @(negedge clk);
    if (rnd_din) din = 24'($urandom);
    apply(s, a);
  endtask

  // Monitor
  always @(posedge clk) begin
    cyc++;
    #1;
    if (reset) begin
      check("rst_y", y, 0);
      check("rst_y_valid", y_valid, 0);
      check("rst_cur_ch", cur_ch, 0);
      check("rst_switching", switching, 0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("y", y, e.y);
      check("y_valid", y_valid, e.v);
      check("cur_ch", cur_ch, e.ch);
      check("switching", switching, e.sw);
    end
  end

  logic [3:0] rs;
  logic       ra;
  int         hold;
  int         guard;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    apply(4'b0000, 1'b0);
    repeat (4) tick(4'b0000, 1'b0);
    // Held request to ch1, then back to ch0
    repeat (8) tick(4'b0100, 1'b0);
    repeat (8) tick(4'b0000, 1'b0);
    // One-cycle glitch aborts without blanking
    tick(4'b0100, 1'b0);
    repeat (6) tick(4'b0000, 1'b0);
    // Out-of-range request on ch0, then from ch2
    repeat (6) tick(4'b1100, 1'b0);
    repeat (8) tick(4'b1000, 1'b0);
    repeat (8) tick(4'b1100, 1'b0);
    // Auto rotation through all channels, switches ignored
    repeat (25) tick(4'($urandom), 1'b1);
    repeat (6) tick(4'b0000, 1'b0);
    // Random switch activity with random data
    for (int i = 0; i < 150; i++) begin
      rs   = 4'($urandom);
      ra   = ($urandom_range(0, 9) == 0);
      hold = ra ? $urandom_range(3, 14) : $urandom_range(1, 6);
      repeat (hold) tick(rs, ra, 1'b1);
    end
    // Drive into BLANK and reset there
    guard = 0;
    while (m_blank == 0 && guard < 50) begin
      tick((m_cur == 0) ? 4'b0100 : 4'b0000, 1'b0);
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL blank_reach cyc=%0d got=timeout exp=blank", cyc);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_y", y, 0);
    check("async_rst_y_valid", y_valid, 0);
    check("async_rst_cur_ch", cur_ch, 0);
    check("async_rst_switching", switching, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    din = 24'h332211;
    apply(4'b0000, 1'b0);
    repeat (5) tick(4'b0000, 1'b0);
    @(posedge clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
